// File: rtl/demux_pkg.sv
// Shared types and constants for the buffered 1-to-4 demultiplexer.
package demux_pkg;
    localparam int N_CH  = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;
endpackage

// File: rtl/demux_slot.sv
// One output channel: single-entry slot with EMPTY/FULL control,
// data register and saturating transfer counter.
//   state | meaning
//   EMPTY | no word held, channel can take a new word
//   FULL  | word held and presented downstream
module demux_slot
    import demux_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CNT_W-1:0]  cnt_o
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    slot_state_e       state_q, state_d;
    logic [DATA_W-1:0] data_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              xfer;

    assign valid_o = (state_q == FULL);
    assign data_o  = data_q;
    assign cnt_o   = cnt_q;
    assign xfer    = valid_o & ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (wr_i) data_q <= data_i;
            if (xfer && (cnt_q != CNT_MAX)) cnt_q <= cnt_q + 1'b1;
        end
    end

    // A write into a FULL slot only happens alongside a drain, so it stays FULL.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (wr_i) state_d = FULL;
            FULL:    if (xfer && !wr_i) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end
endmodule

// File: rtl/demux_1_4_buf.sv
// Buffered 1-to-4 demultiplexer: routes each upstream word into the
// selected channel's one-entry slot with ready/valid on both sides.
module demux_1_4_buf
    import demux_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid_i,
    input  logic [SEL_W-1:0]  in_sel_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    output logic [N_CH-1:0]   out_valid_o,
    output logic [DATA_W-1:0] out_data_0_o,
    output logic [DATA_W-1:0] out_data_1_o,
    output logic [DATA_W-1:0] out_data_2_o,
    output logic [DATA_W-1:0] out_data_3_o,
    input  logic [N_CH-1:0]   out_ready_i,
    output logic [CNT_W-1:0]  cnt_0_o,
    output logic [CNT_W-1:0]  cnt_1_o,
    output logic [CNT_W-1:0]  cnt_2_o,
    output logic [CNT_W-1:0]  cnt_3_o
);
    logic [N_CH-1:0]   wr;
    logic [DATA_W-1:0] data_arr [N_CH];
    logic [CNT_W-1:0]  cnt_arr  [N_CH];

    // Selected slot can accept if empty or draining in this same cycle.
    assign in_ready_o = ~out_valid_o[in_sel_i] | out_ready_i[in_sel_i];

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        assign wr[k] = in_valid_i & in_ready_o & (in_sel_i == SEL_W'(k));

        demux_slot #(
            .DATA_W (DATA_W),
            .CNT_W  (CNT_W)
        ) u_slot (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .wr_i    (wr[k]),
            .data_i  (in_data_i),
            .ready_i (out_ready_i[k]),
            .valid_o (out_valid_o[k]),
            .data_o  (data_arr[k]),
            .cnt_o   (cnt_arr[k])
        );
    end

    assign out_data_0_o = data_arr[0];
    assign out_data_1_o = data_arr[1];
    assign out_data_2_o = data_arr[2];
    assign out_data_3_o = data_arr[3];
    assign cnt_0_o      = cnt_arr[0];
    assign cnt_1_o      = cnt_arr[1];
    assign cnt_2_o      = cnt_arr[2];
    assign cnt_3_o      = cnt_arr[3];
endmodule

// File: tb/tb_demux_1_4_buf.sv
// Scoreboard bench for demux_1_4_buf: directed scenarios plus random traffic
// checked against per-channel queues of expected words.
module tb_demux_1_4_buf;
    localparam int DW   = 32;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [1:0]    in_sel = 2'd0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic [3:0]    out_valid;
    logic [3:0]    out_ready = 4'h0;
    logic [DW-1:0] od [4];
    logic [CW-1:0] oc [4];

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] q [4][$];
    int            mcnt [4];

    demux_1_4_buf #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .in_valid_i   (in_valid),
        .in_sel_i     (in_sel),
        .in_data_i    (in_data),
        .in_ready_o   (in_ready),
        .out_valid_o  (out_valid),
        .out_data_0_o (od[0]),
        .out_data_1_o (od[1]),
        .out_data_2_o (od[2]),
        .out_data_3_o (od[3]),
        .out_ready_i  (out_ready),
        .cnt_0_o      (oc[0]),
        .cnt_1_o      (oc[1]),
        .cnt_2_o      (oc[2]),
        .cnt_3_o      (oc[3])
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: outputs checked mid-cycle, then the model advances to the next edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                q[k].delete();
                mcnt[k] = 0;
            end
        end else begin
            logic exp_rdy;
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("valid%0d", k), 64'(out_valid[k]), 64'(q[k].size() != 0));
                if (q[k].size() != 0) chk($sformatf("data%0d", k), 64'(od[k]), 64'(q[k][0]));
                chk($sformatf("cnt%0d", k), 64'(oc[k]), 64'(mcnt[k]));
            end
            exp_rdy = (q[in_sel].size() == 0) || out_ready[in_sel];
            chk("in_ready", 64'(in_ready), 64'(exp_rdy));
            for (int k = 0; k < 4; k++) begin
                if (q[k].size() != 0 && out_ready[k]) begin
                    void'(q[k].pop_front());
                    if (mcnt[k] < CMAX) mcnt[k]++;
                end
            end
            if (in_valid && exp_rdy) q[in_sel].push_back(in_data);
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [DW-1:0] d, input logic [3:0] r);
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_valid"}, 64'(out_valid), 64'h0);
        chk({tag, "_ready"}, 64'(in_ready), 64'h1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s_data%0d", tag, k), 64'(od[k]), 64'h0);
            chk($sformatf("%s_cnt%0d", tag, k), 64'(oc[k]), 64'h0);
        end
    endtask

    task automatic apply_reset;
        drive(1'b0, 2'd0, '0, 4'h0);
        rst_n = 1'b0;
        step();
        reset_checks("rst");
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        step();
        apply_reset();

        // basic route
        drive(1'b1, 2'd2, 32'hDEADBEEF, 4'hF);
        step();
        drive(1'b0, 2'd0, '0, 4'hF);
        chk("route_valid", 64'(out_valid), 64'h4);
        chk("route_data", 64'(od[2]), 64'hDEADBEEF);
        step();
        chk("route_cnt2", 64'(oc[2]), 64'd1);

        // backpressure
        drive(1'b1, 2'd1, 32'h11, 4'h0);
        step();
        drive(1'b1, 2'd1, 32'h22, 4'h0);
        #1 chk("bp_ready_low", 64'(in_ready), 64'h0);
        step(); step(); step();
        chk("bp_hold", 64'(od[1]), 64'h11);
        drive(1'b1, 2'd1, 32'h22, 4'h2);
        step();
        drive(1'b0, 2'd0, '0, 4'h2);
        chk("bp_next", 64'(od[1]), 64'h22);
        step();

        // independence
        drive(1'b1, 2'd3, 32'hAA, 4'h0);
        step();
        drive(1'b1, 2'd0, 32'h5, 4'h0);
        #1 chk("ind_ready", 64'(in_ready), 64'h1);
        step();
        drive(1'b0, 2'd0, '0, 4'h0);
        chk("ind_valid", 64'(out_valid), 64'h9);
        chk("ind_data3", 64'(od[3]), 64'hAA);
        drive(1'b0, 2'd0, '0, 4'hF);
        step(); step();

        // throughput
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 2'd0, 32'h100 + DW'(i), 4'h1);
            #1 chk($sformatf("tp_ready%0d", i), 64'(in_ready), 64'h1);
            step();
        end
        drive(1'b0, 2'd0, '0, 4'h1);
        step();
        chk("tp_cnt0", 64'(oc[0]), 64'd10);

        // saturation
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 2'd1, DW'(i), 4'h2);
            step();
        end
        drive(1'b0, 2'd0, '0, 4'h2);
        step();
        chk("sat_cnt1", 64'(oc[1]), 64'(CMAX));

        // random traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), DW'($urandom),
                  4'($urandom_range(0, 15)));
            step();
        end
        drive(1'b0, 2'd0, '0, 4'hF);
        step(); step();

        // mid-operation asynchronous reset
        for (int s = 0; s < 4; s++) begin
            drive(1'b1, 2'(s), 32'hC0 + DW'(s), 4'h0);
            step();
        end
        drive(1'b0, 2'd0, '0, 4'h0);
        chk("full_valid", 64'(out_valid), 64'hF);
        #2 rst_n = 1'b0;
        #1 reset_checks("async");
        step(); step();
        rst_n = 1'b1;
        drive(1'b0, 2'd0, '0, 4'hF);
        step(); step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1);
    end
endmodule
